// File: rtl/divider_share_ctrl.sv
// divider_share_ctrl: round-robin front end that lets N_REQ requesters share
// a single iterative divider. It grants one request at a time, drives the
// divider's start/done handshake and returns the result tagged with the
// requester ID. A zero divisor is answered directly without using the divider.
// A divider that never signals done is aborted after TIMEOUT cycles.
module divider_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_divisor,
  input  logic [N_REQ*DATA_W-1:0]   req_dividend,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic [DATA_W-1:0]         rsp_remainder,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      div_start_sig,
  output logic [DATA_W-1:0]         div_divisor,
  output logic [DATA_W-1:0]         div_dividend,
  input  logic                      div_done_sig,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic [DATA_W-1:0]         div_reminder
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    req_ack_q, req_ack_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_quotient_q, rsp_quotient_d;
  logic [DATA_W-1:0]   rsp_remainder_q, rsp_remainder_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                div_start_q, div_start_d;
  logic [DATA_W-1:0]   div_divisor_q, div_divisor_d;
  logic [DATA_W-1:0]   div_dividend_q, div_dividend_d;

  logic                found;
  logic [ID_W-1:0]     winner;
  logic [DATA_W-1:0]   win_divisor;
  logic [DATA_W-1:0]   win_dividend;

  // Index arithmetic modulo N_REQ (N_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search: first valid requester at or above the pointer, with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[wrap_add(rr_ptr_q, k)]) begin
        found  = 1'b1;
        winner = wrap_add(rr_ptr_q, k);
      end
    end
    win_divisor  = req_divisor[int'(winner)*DATA_W +: DATA_W];
    win_dividend = req_dividend[int'(winner)*DATA_W +: DATA_W];
  end

  // Next-state and registered-output logic for the IDLE/BUSY/RESP sequencer.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    cur_id_d        = cur_id_q;
    cnt_d           = cnt_q;
    req_ack_d       = '0;
    rsp_valid_d     = 1'b0;
    rsp_id_d        = rsp_id_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_err_d       = rsp_err_q;
    div_start_d     = div_start_q;
    div_divisor_d   = div_divisor_q;
    div_dividend_d  = div_dividend_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          req_ack_d[winner] = 1'b1;
          div_divisor_d     = win_divisor;
          div_dividend_d    = win_dividend;
          cur_id_d          = winner;
          rr_ptr_d          = wrap_add(winner, 1);
          if (win_divisor == '0) begin
            // Answer divide-by-zero directly; the divider is never started.
            rsp_valid_d     = 1'b1;
            rsp_id_d        = winner;
            rsp_quotient_d  = '1;
            rsp_remainder_d = win_dividend;
            rsp_err_d       = 1'b1;
            state_d         = ST_RESP;
          end else begin
            div_start_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done_sig) begin
          // Done has priority over a timeout in the same cycle.
          rsp_valid_d     = 1'b1;
          rsp_id_d        = cur_id_q;
          rsp_quotient_d  = div_quotient;
          rsp_remainder_d = div_reminder;
          rsp_err_d       = 1'b0;
          div_start_d     = 1'b0;
          state_d         = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d     = 1'b1;
          rsp_id_d        = cur_id_q;
          rsp_quotient_d  = '0;
          rsp_remainder_d = '0;
          rsp_err_d       = 1'b1;
          div_start_d     = 1'b0;
          state_d         = ST_RESP;
        end
      end

      ST_RESP: begin
        // Wait for the divider to release done before another start can issue.
        if (!div_done_sig) state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        div_start_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; async reset drops div_start_sig immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= '0;
      cur_id_q        <= '0;
      cnt_q           <= '0;
      req_ack_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_err_q       <= 1'b0;
      busy_q          <= 1'b0;
      div_start_q     <= 1'b0;
      div_divisor_q   <= '0;
      div_dividend_q  <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      cur_id_q        <= cur_id_d;
      cnt_q           <= cnt_d;
      req_ack_q       <= req_ack_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_err_q       <= rsp_err_d;
      busy_q          <= busy_d;
      div_start_q     <= div_start_d;
      div_divisor_q   <= div_divisor_d;
      div_dividend_q  <= div_dividend_d;
    end
  end

  assign req_ack       = req_ack_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = busy_q;
  assign div_start_sig = div_start_q;
  assign div_divisor   = div_divisor_q;
  assign div_dividend  = div_dividend_q;

endmodule

// File: tb/tb_divider_share_ctrl.sv
// Directed testbench for divider_share_ctrl with a behavioural divider model
// whose latency, done-hold length and hang behaviour are adjustable.
module tb_divider_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [7:0]  dvs [4];
  logic [7:0]  dvd [4];
  logic [31:0] req_divisor, req_dividend;
  logic [3:0]  req_ack;
  logic        rsp_valid, rsp_err, busy, div_start_sig;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_quotient, rsp_remainder, div_divisor, div_dividend;
  logic        div_done_sig;
  logic [7:0]  div_quotient, div_reminder;

  int n_chk = 0;
  int n_pass = 0;

  // Divider model controls
  int   m_lat  = 4;
  int   m_hold = 1;
  logic m_hang = 1'b0;
  logic m_busy;
  int   m_cnt, m_hold_cnt;

  assign req_divisor  = {dvs[3], dvs[2], dvs[1], dvs[0]};
  assign req_dividend = {dvd[3], dvd[2], dvd[1], dvd[0]};

  always #5 clk = ~clk;

  divider_share_ctrl #(.N_REQ(4), .ID_W(2), .DATA_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_divisor(req_divisor), .req_dividend(req_dividend),
    .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_err(rsp_err), .busy(busy),
    .div_start_sig(div_start_sig), .div_divisor(div_divisor), .div_dividend(div_dividend),
    .div_done_sig(div_done_sig), .div_quotient(div_quotient), .div_reminder(div_reminder)
  );

  // Behavioural divider: starts on start_sig, answers after m_lat cycles, holds done m_hold cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_hold_cnt <= 0;
      div_done_sig <= 1'b0; div_quotient <= '0; div_reminder <= '0;
    end else if (div_done_sig) begin
      if (m_hold_cnt >= m_hold - 1) begin
        div_done_sig <= 1'b0;
        m_busy <= 1'b0;
      end else begin
        m_hold_cnt <= m_hold_cnt + 1;
      end
    end else if (m_busy) begin
      if (!div_start_sig) begin
        m_busy <= 1'b0;
      end else if (!m_hang && m_cnt >= m_lat - 1) begin
        div_done_sig <= 1'b1;
        div_quotient <= div_dividend / div_divisor;
        div_reminder <= div_dividend % div_divisor;
        m_hold_cnt   <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (div_start_sig) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (req_ack == '0 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_ack_seen"}, 32'(req_ack != '0), 1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_rsp_seen"}, 32'(rsp_valid), 1);
  endtask

  task automatic check_rsp(input string tag, input int id, input int q, input int r, input int e);
    chk({tag, "_id"},  32'(rsp_id), 32'(id));
    chk({tag, "_q"},   32'(rsp_quotient), 32'(q));
    chk({tag, "_r"},   32'(rsp_remainder), 32'(r));
    chk({tag, "_err"}, 32'(rsp_err), 32'(e));
  endtask

  int exp_id [4] = '{1, 2, 3, 1};
  int exp_q  [4] = '{14, 22, 15, 14};
  int exp_r  [4] = '{2, 2, 15, 2};

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin dvs[i] = '0; dvd[i] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {req_ack, rsp_valid, busy, div_start_sig, rsp_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {req_ack, rsp_valid, busy, div_start_sig, rsp_id, rsp_quotient}, 0);

    // Test 1: req 0, 243/10 -> 24 r3
    dvs[0] = 8'd10; dvd[0] = 8'd243; req_valid = 4'b0001;
    @(negedge clk);
    wait_ack("t1");
    chk("t1_ack", 32'(req_ack), 32'h1);
    chk("t1_start", 32'(div_start_sig), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_div_ops", {div_divisor, div_dividend}, {8'd10, 8'd243});
    req_valid = '0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(req_ack), 0);
    chk("t1_start_held", 32'(div_start_sig), 1);
    wait_rsp("t1");
    check_rsp("t1", 0, 24, 3, 0);
    chk("t1_start_dropped", 32'(div_start_sig), 0);
    @(negedge clk);
    chk("t1_rsp_pulse", 32'(rsp_valid), 0);
    chk("t1_hold_q", 32'(rsp_quotient), 24);

    // Test 3: requesters 1,2,3 kept valid -> order 1,2,3,1
    dvs[1] = 8'd7;  dvd[1] = 8'd100;
    dvs[2] = 8'd9;  dvd[2] = 8'd200;
    dvs[3] = 8'd16; dvd[3] = 8'd255;
    req_valid = 4'b1110;
    for (int g = 0; g < 4; g++) begin
      wait_ack("t3");
      chk("t3_grant", 32'(req_ack), 32'(1 << exp_id[g]));
      if (g == 3) req_valid = '0;
      @(negedge clk);
      wait_rsp("t3");
      check_rsp("t3", exp_id[g], exp_q[g], exp_r[g], 0);
      @(negedge clk);
    end

    // Test 2: req 2 divide by zero
    repeat (2) @(negedge clk);
    dvs[2] = 8'd0; dvd[2] = 8'd77; req_valid = 4'b0100;
    @(negedge clk);
    wait_ack("t2");
    chk("t2_ack", 32'(req_ack), 32'h4);
    chk("t2_rsp_with_ack", 32'(rsp_valid), 1);
    chk("t2_no_start", 32'(div_start_sig), 0);
    check_rsp("t2", 2, 8'hFF, 77, 1);
    req_valid = '0;
    @(negedge clk);
    chk("t2_rsp_pulse", 32'(rsp_valid), 0);
    chk("t2_still_no_start", 32'(div_start_sig), 0);

    // Test 4: hung divider -> abort after 64 BUSY cycles
    repeat (2) @(negedge clk);
    m_hang = 1'b1;
    dvs[0] = 8'd3; dvd[0] = 8'd9; req_valid = 4'b0001;
    @(negedge clk);
    wait_ack("t4");
    req_valid = '0;
    n = 0;
    while (div_start_sig && n < 200) begin n++; @(negedge clk); end
    chk("t4_start_cycles", 32'(n), 64);
    chk("t4_rsp_valid", 32'(rsp_valid), 1);
    check_rsp("t4", 0, 0, 0, 1);
    m_hang = 1'b0;
    @(negedge clk);
    dvs[1] = 8'd7; dvd[1] = 8'd50; req_valid = 4'b0010;
    @(negedge clk);
    wait_ack("t4b");
    chk("t4b_ack", 32'(req_ack), 32'h2);
    req_valid = '0;
    @(negedge clk);
    wait_rsp("t4b");
    check_rsp("t4b", 1, 7, 1, 0);

    // Test 5: done held high 3 cycles; no new start while done is high
    repeat (2) @(negedge clk);
    m_hold = 3;
    dvs[3] = 8'd16; dvd[3] = 8'd255; req_valid = 4'b1000;
    @(negedge clk);
    wait_ack("t5");
    req_valid = '0;
    @(negedge clk);
    wait_rsp("t5");
    check_rsp("t5", 3, 15, 15, 0);
    chk("t5_done_still_high", 32'(div_done_sig), 1);
    dvs[0] = 8'd3; dvd[0] = 8'd9; req_valid = 4'b0001;
    n = 0;
    while (div_done_sig && n < 20) begin
      chk("t5_no_start_during_done", 32'(div_start_sig), 0);
      chk("t5_busy_during_done", 32'(busy), 1);
      chk("t5_no_ack_during_done", 32'(req_ack), 0);
      n++;
      @(negedge clk);
    end
    m_hold = 1;
    wait_ack("t5b");
    chk("t5b_ack", 32'(req_ack), 32'h1);
    req_valid = '0;
    @(negedge clk);
    wait_rsp("t5b");
    check_rsp("t5b", 0, 3, 0, 0);

    // Test 6: async reset during BUSY, then requester 0 beats requester 3
    repeat (2) @(negedge clk);
    m_lat = 20;
    dvs[0] = 8'd2; dvd[0] = 8'd8; req_valid = 4'b0001;
    @(negedge clk);
    wait_ack("t6");
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("t6_busy_before_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_start", 32'(div_start_sig), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ack_rsp", {req_ack, rsp_valid}, 0);
    m_lat = 4;
    dvs[0] = 8'd5; dvd[0] = 8'd23;
    dvs[3] = 8'd3; dvd[3] = 8'd30;
    req_valid = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_grant_after_rst", 32'(req_ack), 32'h1);
    req_valid = 4'b1000;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk); n++;
      if (req_ack != '0) chk("t6_no_early_ack", 32'(req_ack), 0);
    end
    chk("t6a_rsp_seen", 32'(rsp_valid), 1);
    check_rsp("t6a", 0, 4, 3, 0);
    @(negedge clk);
    wait_ack("t6b");
    chk("t6b_ack", 32'(req_ack), 32'h8);
    req_valid = '0;
    @(negedge clk);
    wait_rsp("t6b");
    check_rsp("t6b", 3, 10, 0, 0);
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
